au_32b: RTL and testbench
=========================

Name: au_32b

Overview:
32-bit arithmetic unit providing combinational add/subtract and iterative unsigned multiply/divide in a single clock domain. Multiply and divide use a shift-add or restoring-division datapath, one iteration per clock, 32 iterations per operation. Results go to MIPS-style hi/lo registers. It sits in the execute stage beside the ALU and is controlled only by the ALUop code; it has no start/done handshake.

Parameters:
WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
a  input  WIDTH  operand A (multiplicand / dividend)
b  input  WIDTH  operand B (multiplier / divisor)
ALUop  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV
s  output  WIDTH  add/sub result
hi  output  WIDTH  product upper half / division remainder
lo  output  WIDTH  product lower half / division quotient
zero  output  1  zero flag

Behaviour:
- Reset: clk is the single clock; rst_n is synchronous and active-low. While rst_n=0 at a rising edge: hi=0, lo=0, FSM=IDLE, iteration counter=0. s and zero are combinational and not reset.
- ADD: s = a+b, modulo 2^WIDTH, carry discarded.
- SUB: s = a-b, modulo 2^WIDTH.
- When ALUop[1]=1, s=0.
- zero:
  - ALUop[1]=0: zero = (s==0).
  - ALUop[1]=1: zero = (hi==0 && lo==0).
- FSM states: IDLE, BUSY.
- IDLE: at a rising edge with ALUop[1]=1, latch a, b and ALUop[0] into working registers, clear the counter, and go to BUSY. hi/lo are unchanged.
- BUSY: each edge performs one iteration and increments the counter.
  - The 32nd iteration edge writes the final result into hi/lo and returns to IDLE.
  - Result is visible after 33 rising edges, counted from the first edge that sampled MUL/DIV.
- hi/lo change only on a completion edge or on reset. They hold their value between operations and throughout the following operation.
- MUL: unsigned; {hi,lo} = a*b, full 64-bit product.
- DIV: unsigned; lo = a/b, hi = a%b.
  - Divide by zero: lo=0xFFFFFFFF, hi=a (natural restoring-division result); no trap.
- Changes to a, b or ALUop during BUSY are ignored; the latched operation completes.
- If ALUop still selects MUL/DIV while IDLE after completion, a new operation starts on the next edge. Re-running the same operation rewrites identical values.
- Reset during BUSY aborts the operation: hi=lo=0, state IDLE, no later write.
- Switching to ADD/SUB does not disturb hi/lo.

Optional Feature:
AU_OVF_EN
- Defined: adds output port ovf (1 bit, combinational).
  - ADD: ovf = a[31]==b[31] && s[31]!=a[31].
  - SUB: ovf = a[31]!=b[31] && s[31]!=a[31].
  - ovf=0 when ALUop[1]=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package au_pkg holds:
  - the WIDTH default constant;
  - typedef enum alu_op_e {OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11};
  - typedef enum au_state_e {IDLE, BUSY};
  - the iteration-count constant.
- One sub-module, au_muldiv_seq, holds the FSM, counter, shift-add multiplier, restoring divider and hi/lo registers.
- The top level keeps the combinational add/sub, the zero flag and the optional ovf.

Test Plan:
1. Reset: rst_n=0 for 2 edges, then ALUop=00, a=b=0 -> hi=0, lo=0, s=0, zero=1.
2. ADD:
   - 7+5 -> s=12, zero=0.
   - 0xFFFFFFFF+1 -> s=0, zero=1.
   - With AU_OVF_EN, 0x7FFFFFFF+1 -> ovf=1.
3. SUB:
   - 5-7 -> s=0xFFFFFFFE, zero=0.
   - 9-9 -> s=0, zero=1.
4. MUL:
   - 12345*6789 -> after 33 edges hi=0, lo=83810205, zero=0.
   - 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
   - hi/lo unchanged at edge 32.
5. DIV:
   - 100/7 -> after 33 edges lo=14, hi=2.
   - 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234.
6. Robustness:
   - Start MUL 3*4 and change a to 9 at edge 5 -> lo=12.
   - Start MUL and assert rst_n=0 at edge 10 -> hi=lo=0, with no update after reset is released until a new op starts.

Source files
------------

// File: rtl/au_pkg.sv
// Shared constants and types for the au_32b arithmetic unit.
// Optional build macro AU_OVF_EN (used by au_32b) adds a signed-overflow output.
package au_pkg;

  localparam int unsigned AU_WIDTH = 32;
  localparam int unsigned AU_ITERS = AU_WIDTH;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } au_state_e;

endpackage

// File: rtl/au_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one step per clock,
// results landing in MIPS-style hi/lo registers.
module au_muldiv_seq
  import au_pkg::*;
#(
  parameter int unsigned WIDTH = AU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ITERS = WIDTH;
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [0:0] S_IDLE = 1'(IDLE);
  localparam logic [0:0] S_BUSY = 1'(BUSY);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One iteration: work regs hold {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {work_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    opnd_d    = opnd_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    hi_d      = hi;
    lo_d      = lo;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_BUSY;
          cnt_d     = '0;
          is_div_d  = op_div;
          opnd_d    = op_div ? b : a;
          work_hi_d = '0;
          work_lo_d = op_div ? a : b;
        end
      end
      S_BUSY: begin
        cnt_d     = cnt_q + CNT_W'(1);
        work_hi_d = step_hi;
        work_lo_d = step_lo;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = S_IDLE;
          hi_d    = step_hi;
          lo_d    = step_lo;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      opnd_q    <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      opnd_q    <= opnd_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      hi        <= hi_d;
      lo        <= lo_d;
    end
  end

endmodule

// File: rtl/au_32b.sv
// Execute-stage arithmetic unit: combinational add/sub plus sequential mul/div into hi/lo.
// Define AU_OVF_EN to add the combinational signed-overflow output ovf.
module au_32b
  import au_pkg::*;
#(
  parameter int unsigned WIDTH = AU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ALUop,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero
`ifdef AU_OVF_EN
  ,
  output logic             ovf
`endif
);

  au_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (ALUop[1]),
    .op_div (ALUop[0]),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo)
  );

  // Add/sub result; mul/div report through hi/lo so s reads zero.
  always_comb begin
    s = '0;
    case (ALUop)
      OP_ADD:  s = a + b;
      OP_SUB:  s = a - b;
      default: s = '0;
    endcase
  end

  always_comb begin
    zero = 1'b0;
    if (ALUop[1]) zero = (hi == '0) && (lo == '0);
    else          zero = (s == '0);
  end

`ifdef AU_OVF_EN
  always_comb begin
    ovf = 1'b0;
    case (ALUop)
      OP_ADD:  ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  ovf = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

endmodule

// File: tb/tb_au_32b.sv
// Directed self-checking bench for au_32b: add/sub, mul/div latency and results, abort on reset.
module tb_au_32b;
  import au_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [1:0]  ALUop;
  logic [31:0] s, hi, lo;
  logic        zero;
`ifdef AU_OVF_EN
  logic        ovf;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  au_32b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .ALUop (ALUop),
    .s     (s),
    .hi    (hi),
    .lo    (lo),
    .zero  (zero)
`ifdef AU_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Inputs change and outputs are sampled on falling edges; each step crosses one rising edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    ALUop = op;
    a     = av;
    b     = bv;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(OP_ADD, 32'd0, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_s", s, 32'd0);
    chk("reset_zero", 32'(zero), 32'd1);

    drive(OP_ADD, 32'd7, 32'd5);
    step(1);
    chk("add_s", s, 32'd12);
    chk("add_zero", 32'(zero), 32'd0);

    drive(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    step(1);
    chk("add_wrap_s", s, 32'd0);
    chk("add_wrap_zero", 32'(zero), 32'd1);

`ifdef AU_OVF_EN
    drive(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    step(1);
    chk("add_ovf", 32'(ovf), 32'd1);
    drive(OP_SUB, 32'h8000_0000, 32'd1);
    step(1);
    chk("sub_ovf", 32'(ovf), 32'd1);
    drive(OP_ADD, 32'd7, 32'd5);
    step(1);
    chk("add_no_ovf", 32'(ovf), 32'd0);
`endif

    drive(OP_SUB, 32'd5, 32'd7);
    step(1);
    chk("sub_s", s, 32'hFFFF_FFFE);
    chk("sub_zero", 32'(zero), 32'd0);

    drive(OP_SUB, 32'd9, 32'd9);
    step(1);
    chk("sub_eq_s", s, 32'd0);
    chk("sub_eq_zero", 32'(zero), 32'd1);

    // MUL 12345*6789: nothing lands until edge 33
    drive(OP_MUL, 32'd12345, 32'd6789);
    step(32);
    chk("mul_edge32_lo", lo, 32'd0);
    chk("mul_edge32_hi", hi, 32'd0);
    chk("mul_s_forced0", s, 32'd0);
    step(1);
    chk("mul_lo", lo, 32'd83810205);
    chk("mul_hi", hi, 32'd0);
    chk("mul_zero", 32'(zero), 32'd0);

    // Still MUL in IDLE: re-run writes the same values
    step(33);
    chk("mul_rerun_lo", lo, 32'd83810205);
    chk("mul_rerun_hi", hi, 32'd0);

    drive(OP_ADD, 32'd1, 32'd2);
    step(3);
    chk("add_keeps_lo", lo, 32'd83810205);
    chk("add_s2", s, 32'd3);

    drive(OP_MUL, 32'hFFFF_FFFF, 32'd2);
    step(33);
    chk("mul_big_hi", hi, 32'd1);
    chk("mul_big_lo", lo, 32'hFFFF_FFFE);
    drive(OP_ADD, 32'd0, 32'd0);

    drive(OP_DIV, 32'd100, 32'd7);
    step(33);
    chk("div_lo", lo, 32'd14);
    chk("div_hi", hi, 32'd2);
    chk("div_zero_flag", 32'(zero), 32'd0);
    drive(OP_ADD, 32'd0, 32'd0);

    drive(OP_DIV, 32'h0000_1234, 32'd0);
    step(33);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'h0000_1234);
    drive(OP_ADD, 32'd0, 32'd0);

    // Operand and opcode changes mid-operation are ignored
    drive(OP_MUL, 32'd3, 32'd4);
    step(5);
    drive(OP_ADD, 32'd9, 32'd4);
    step(28);
    chk("mul_latched_lo", lo, 32'd12);
    chk("mul_latched_hi", hi, 32'd0);

    // Reset mid-operation aborts it
    drive(OP_MUL, 32'd5, 32'd6);
    step(10);
    rst_n = 1'b0;
    drive(OP_ADD, 32'd0, 32'd0);
    step(1);
    rst_n = 1'b1;
    chk("abort_lo", lo, 32'd0);
    chk("abort_hi", hi, 32'd0);
    step(40);
    chk("abort_late_lo", lo, 32'd0);
    chk("abort_late_hi", hi, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
